serial_comparator: RTL and testbench

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

---
 rtl/serial_comparator_pkg.sv | 20 ++
 rtl/serial_comparator_if.sv | 34 +++
 rtl/serial_comparator_bit_cell.sv | 26 ++
 rtl/serial_comparator.sv | 116 +++++++++++
 tb/tb_serial_comparator.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/serial_comparator_pkg.sv
// ============================================================================
// Module : serial_comparator_pkg
// Brief  : Shared FSM state type and default operand width for serial_comparator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package serial_comparator_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_comparator_if.sv
// ============================================================================
// Module : serial_comparator_if
// Brief  : Request/operand inputs and status/result outputs of serial_comparator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface serial_comparator_if
    import serial_comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             GT;
    logic             LT;
    logic             EQ;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, GT, LT, EQ
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, GT, LT, EQ
    );
endinterface

`default_nettype wire

// File: rtl/serial_comparator_bit_cell.sv
// ============================================================================
// Module : serial_comparator_bit_cell
// Brief  : Combinational single-bit magnitude decision for the serial compare.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module serial_comparator_bit_cell (
    input  wire logic a_bit,
    input  wire logic b_bit,
    input  wire logic is_msb,
    input  wire logic signed_mode,
    output logic      differ,
    output logic      gt,
    output logic      lt
);
    logic invert;

    // A set sign bit means the smaller value, so the MSB decision flips.
    assign invert = is_msb & signed_mode;
    assign differ = a_bit ^ b_bit;
    assign gt     = differ & (invert ? b_bit : a_bit);
    assign lt     = differ & (invert ? a_bit : b_bit);
endmodule

`default_nettype wire

// File: rtl/serial_comparator.sv
// ============================================================================
// Module : serial_comparator
// Brief  : Bit-serial MSB-first signed/unsigned magnitude comparator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module serial_comparator
    import serial_comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_comparator_if.slave bus
);
    localparam int                IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]  MSB_IDX = IDX_W'(WIDTH - 1);

    state_t           state,      state_next;
    logic [WIDTH-1:0] a_reg,      a_next;
    logic [WIDTH-1:0] b_reg,      b_next;
    logic             smode_reg,  smode_next;
    logic [IDX_W-1:0] idx_reg,    idx_next;
    logic             gt_reg,     gt_next;
    logic             lt_reg,     lt_next;
    logic             eq_reg,     eq_next;

    logic bit_differ;
    logic bit_gt;
    logic bit_lt;

    serial_comparator_bit_cell u_bit_cell (
        .a_bit       (a_reg[idx_reg]),
        .b_bit       (b_reg[idx_reg]),
        .is_msb      (idx_reg == MSB_IDX),
        .signed_mode (smode_reg),
        .differ      (bit_differ),
        .gt          (bit_gt),
        .lt          (bit_lt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            smode_reg <= 1'b0;
            idx_reg   <= MSB_IDX;
            gt_reg    <= 1'b0;
            lt_reg    <= 1'b0;
            eq_reg    <= 1'b0;
        end else begin
            state     <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            smode_reg <= smode_next;
            idx_reg   <= idx_next;
            gt_reg    <= gt_next;
            lt_reg    <= lt_next;
            eq_reg    <= eq_next;
        end
    end

    always_comb begin
        state_next = state;
        a_next     = a_reg;
        b_next     = b_reg;
        smode_next = smode_reg;
        idx_next   = idx_reg;
        gt_next    = gt_reg;
        lt_next    = lt_reg;
        eq_next    = eq_reg;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    a_next     = bus.a;
                    b_next     = bus.b;
                    smode_next = bus.signed_mode;
                    idx_next   = MSB_IDX;
                    gt_next    = 1'b0;
                    lt_next    = 1'b0;
                    eq_next    = 1'b0;
                    state_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (bit_differ) begin
                    gt_next    = bit_gt;
                    lt_next    = bit_lt;
                    state_next = S_DONE;
                end else if (idx_reg == '0) begin
                    eq_next    = 1'b1;
                    state_next = S_DONE;
                end else begin
                    idx_next   = idx_reg - IDX_W'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);
    assign bus.GT   = gt_reg;
    assign bus.LT   = lt_reg;
    assign bus.EQ   = eq_reg;
endmodule

`default_nettype wire

// File: tb/tb_serial_comparator.sv
// ============================================================================
// Module : tb_serial_comparator
// Brief  : Self-checking bench: directed cases plus random traffic vs a model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_serial_comparator;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    bit   run_chk;

    serial_comparator_if #(.WIDTH(WIDTH)) bus ();

    serial_comparator #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Leading equal bits from the MSB, i.e. the position of the deciding bit.
    function automatic int first_diff_pos(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        for (int i = WIDTH - 1; i >= 0; i--)
            if (x[i] != y[i]) return WIDTH - 1 - i;
        return WIDTH - 1;
    endfunction

    function automatic int as_int(input logic [WIDTH-1:0] x, input logic sm);
        if (sm) return int'($signed(x));
        return int'({1'b0, x});
    endfunction

    // Behavioural model: result from integer compare, timing from the latency rule.
    logic m_busy, m_done, m_gt, m_lt, m_eq;
    logic p_gt, p_lt, p_eq;
    int   m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0;
            m_gt <= 1'b0; m_lt <= 1'b0; m_eq <= 1'b0;
            m_left <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 0) begin
                m_done <= 1'b1;
                m_gt <= p_gt; m_lt <= p_lt; m_eq <= p_eq;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (bus.start) begin
            m_busy <= 1'b1;
            m_gt <= 1'b0; m_lt <= 1'b0; m_eq <= 1'b0;
            m_left <= first_diff_pos(bus.a, bus.b);
            p_gt <= as_int(bus.a, bus.signed_mode) >  as_int(bus.b, bus.signed_mode);
            p_lt <= as_int(bus.a, bus.signed_mode) <  as_int(bus.b, bus.signed_mode);
            p_eq <= as_int(bus.a, bus.signed_mode) == as_int(bus.b, bus.signed_mode);
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("done", 32'(bus.done), 32'(m_done));
            check("GT",   32'(bus.GT),   32'(m_gt));
            check("LT",   32'(bus.LT),   32'(m_lt));
            check("EQ",   32'(bus.EQ),   32'(m_eq));
            if (bus.done)
                check("onehot", 32'(bus.GT) + 32'(bus.LT) + 32'(bus.EQ), 32'd1);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Start one compare; cycle 1 follows the acceptance edge.
    task automatic directed(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                            input logic sm, input int exp_cyc,
                            input logic eg, input logic el, input logic ee);
        int cyc;
        wait_idle();
        bus.a = av; bus.b = bv; bus.signed_mode = sm; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_res"}, {29'd0, bus.GT, bus.LT, bus.EQ}, {29'd0, eg, el, ee});
    endtask

    initial begin
        n_checks = 0; n_fail = 0; run_chk = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outs", {27'd0, bus.busy, bus.done, bus.GT, bus.LT, bus.EQ}, 32'd0);
        rst = 1'b0;
        run_chk = 1'b1;

        directed("u80_7f", 8'h80, 8'h7F, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        directed("u5a_5a", 8'h5A, 8'h5A, 1'b0, 9, 1'b0, 1'b0, 1'b1);
        directed("s80_01", 8'h80, 8'h01, 1'b1, 2, 1'b0, 1'b1, 1'b0);
        directed("sfe_fd", 8'hFE, 8'hFD, 1'b1, 8, 1'b1, 1'b0, 1'b0);
        directed("s00_ff", 8'h00, 8'hFF, 1'b1, 2, 1'b1, 1'b0, 1'b0);
        directed("u00_ff", 8'h00, 8'hFF, 1'b0, 2, 1'b0, 1'b1, 1'b0);
        directed("u01_00", 8'h01, 8'h00, 1'b0, 9, 1'b1, 1'b0, 1'b0);

        // Start held high with operands churning every cycle.
        wait_idle();
        for (int i = 0; i < 300; i++) begin
            bus.start = 1'b1;
            bus.a = WIDTH'($urandom);
            bus.b = ($urandom_range(0, 3) == 0) ? bus.a : WIDTH'($urandom);
            bus.signed_mode = 1'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;

        // Sparse random starts.
        for (int i = 0; i < 400; i++) begin
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a = WIDTH'($urandom);
            bus.b = ($urandom_range(0, 3) == 0) ? bus.a ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1)) : WIDTH'($urandom);
            bus.signed_mode = 1'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;

        // Abort an equal-operand compare with an asynchronous reset.
        wait_idle();
        bus.a = 8'h5A; bus.b = 8'h5A; bus.signed_mode = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("abort_outs", {27'd0, bus.busy, bus.done, bus.GT, bus.LT, bus.EQ}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        directed("u03_04", 8'h03, 8'h04, 1'b0, 7, 1'b0, 1'b1, 1'b0);

        wait_idle();
        repeat (2) @(negedge clk);
        run_chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
